// File: rtl/seq_divider_param.sv
// Multi-cycle restoring divider with start/busy/valid handshake.
// Optional C-style signed division with divide-by-zero and overflow flags.
`timescale 1ns/1ps
module seq_divider_param #(
   parameter int WIDTH     = 8,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             valid,
   output logic             dvz,
   output logic             ovf,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_ITER = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]       state;
   logic [WIDTH-1:0] dd_r, ds_r;
   logic             sm_r;
   logic [WIDTH-1:0] rem_w, quo_w, dvs_w;
   logic             neg_q, neg_r;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   shifted, trial;

   // The partial remainder is always below the divisor, so WIDTH bits hold it;
   // only the shifted trial value needs the extra bit.
   assign shifted = {rem_w, quo_w[WIDTH-1]};
   assign trial   = shifted - {1'b0, dvs_w};

   assign busy  = (state == S_LOAD) || (state == S_ITER) || (state == S_FIX);
   assign valid = (state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         dd_r      <= '0;
         ds_r      <= '0;
         sm_r      <= 1'b0;
         rem_w     <= '0;
         quo_w     <= '0;
         dvs_w     <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         cnt       <= '0;
         dvz       <= 1'b0;
         ovf       <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  dd_r  <= dividend;
                  ds_r  <= divisor;
                  sm_r  <= SIGNED_EN && signed_mode;
                  dvz   <= 1'b0;
                  ovf   <= 1'b0;
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (ds_r == '0) begin
                  dvz       <= 1'b1;
                  quotient  <= '1;
                  remainder <= dd_r;
                  state     <= S_DONE;
               end else if (sm_r && (dd_r == MIN_NEG) && (ds_r == '1)) begin
                  ovf       <= 1'b1;
                  quotient  <= MIN_NEG;
                  remainder <= '0;
                  state     <= S_DONE;
               end else begin
                  // Magnitudes go through the unsigned core; signs are reapplied in FIX.
                  neg_q <= sm_r && (dd_r[WIDTH-1] ^ ds_r[WIDTH-1]);
                  neg_r <= sm_r && dd_r[WIDTH-1];
                  quo_w <= (sm_r && dd_r[WIDTH-1]) ? -dd_r : dd_r;
                  dvs_w <= (sm_r && ds_r[WIDTH-1]) ? -ds_r : ds_r;
                  rem_w <= '0;
                  cnt   <= '0;
                  state <= S_ITER;
               end
            end
            S_ITER: begin
               if (!trial[WIDTH]) begin
                  rem_w <= trial[WIDTH-1:0];
                  quo_w <= {quo_w[WIDTH-2:0], 1'b1};
               end else begin
                  rem_w <= shifted[WIDTH-1:0];
                  quo_w <= {quo_w[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH-1))
                  state <= S_FIX;
            end
            S_FIX: begin
               quotient  <= neg_q ? -quo_w : quo_w;
               remainder <= neg_r ? -rem_w : rem_w;
               state     <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_divider_param.sv
// Directed bench for seq_divider_param (WIDTH=8, signed enabled): results,
// flags, latency, start-while-busy, and mid-operation reset.
`timescale 1ns/1ps
module tb_seq_divider_param;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       signed_mode;
   logic [7:0] dividend, divisor;
   logic       busy, valid, dvz, ovf;
   logic [7:0] quotient, remainder;

   int n_cmp = 0;
   int n_err = 0;
   int edges;

   seq_divider_param #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
      .dividend(dividend), .divisor(divisor), .busy(busy), .valid(valid),
      .dvz(dvz), .ovf(ovf), .quotient(quotient), .remainder(remainder)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Edge count is inclusive of the capture edge; bounded so a dead DUT cannot hang.
   task automatic wait_valid(output int e);
      e = 1;
      while (!valid && e < 40) begin
         @(posedge clk); #1;
         e++;
      end
      chk("valid_seen", valid, 1);
   endtask

   task automatic do_op(input logic sm, input logic [7:0] dd, input logic [7:0] ds, output int e);
      @(negedge clk);
      start = 1'b1; signed_mode = sm; dividend = dd; divisor = ds;
      @(posedge clk); #1;
      start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
      chk("busy_after_start", busy, 1);
      wait_valid(e);
   endtask

   task automatic finish_op();
      @(posedge clk); #1;
      chk("valid_one_cycle", valid, 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);   chk("rst_valid", valid, 0);
      chk("rst_dvz", dvz, 0);     chk("rst_ovf", ovf, 0);
      chk("rst_q", quotient, 0);  chk("rst_r", remainder, 0);
      @(negedge clk); rst_n = 1'b1;

      // unsigned 100/7
      do_op(1'b0, 8'd100, 8'd7, edges);
      chk("u100_7_lat", edges, 11);
      chk("u100_7_q", quotient, 8'd14); chk("u100_7_r", remainder, 8'd2);
      chk("u100_7_dvz", dvz, 0);        chk("u100_7_ovf", ovf, 0);
      chk("u100_7_busy", busy, 0);
      finish_op();

      // signed, mixed operand signs
      do_op(1'b1, 8'h9C, 8'h07, edges);
      chk("sm100_7_q", quotient, 8'hF2); chk("sm100_7_r", remainder, 8'hFE);
      finish_op();
      do_op(1'b1, 8'd100, 8'hF9, edges);
      chk("s100_m7_q", quotient, 8'hF2); chk("s100_m7_r", remainder, 8'h02);
      finish_op();

      // divide by zero, then cleared by next start
      do_op(1'b0, 8'd200, 8'd0, edges);
      chk("dvz_lat", edges, 2);
      chk("dvz_flag", dvz, 1);  chk("dvz_ovf", ovf, 0);
      chk("dvz_q", quotient, 8'hFF); chk("dvz_r", remainder, 8'hC8);
      finish_op();
      chk("dvz_held", dvz, 1);
      do_op(1'b0, 8'd9, 8'd3, edges);
      chk("u9_3_dvz", dvz, 0);
      chk("u9_3_q", quotient, 8'd3); chk("u9_3_r", remainder, 8'd0);
      finish_op();

      // signed overflow vs the same bits unsigned
      do_op(1'b1, 8'h80, 8'hFF, edges);
      chk("ovf_lat", edges, 2);
      chk("ovf_flag", ovf, 1); chk("ovf_dvz", dvz, 0);
      chk("ovf_q", quotient, 8'h80); chk("ovf_r", remainder, 8'h00);
      finish_op();
      chk("ovf_held", ovf, 1);
      do_op(1'b0, 8'h80, 8'hFF, edges);
      chk("u80_ff_ovf", ovf, 0);
      chk("u80_ff_q", quotient, 8'h00); chk("u80_ff_r", remainder, 8'h80);
      finish_op();

      // start held high with operands churning during the operation
      @(negedge clk);
      start = 1'b1; signed_mode = 1'b0; dividend = 8'd255; divisor = 8'd1;
      @(posedge clk); #1;
      edges = 1;
      while (!valid && edges < 40) begin
         dividend = 8'($urandom); divisor = 8'($urandom);
         @(posedge clk); #1;
         edges++;
      end
      chk("hold_valid", valid, 1);
      chk("hold_lat", edges, 11);
      chk("hold_q", quotient, 8'd255); chk("hold_r", remainder, 8'd0);
      dividend = 8'd50; divisor = 8'd5;
      @(posedge clk); #1;
      chk("hold_idle_busy", busy, 0); chk("hold_idle_valid", valid, 0);
      @(posedge clk); #1;
      chk("hold_restart_busy", busy, 1);
      start = 1'b0;
      wait_valid(edges);
      chk("hold2_lat", edges, 11);
      chk("hold2_q", quotient, 8'd10); chk("hold2_r", remainder, 8'd0);
      finish_op();

      // asynchronous reset while iterating
      @(negedge clk);
      start = 1'b1; signed_mode = 1'b0; dividend = 8'd200; divisor = 8'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2; rst_n = 1'b0; #1;
      chk("arst_busy", busy, 0); chk("arst_valid", valid, 0);
      chk("arst_dvz", dvz, 0);   chk("arst_ovf", ovf, 0);
      chk("arst_q", quotient, 0); chk("arst_r", remainder, 0);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         chk("arst_no_valid", valid, 0);
      end
      do_op(1'b0, 8'd13, 8'd4, edges);
      chk("u13_4_lat", edges, 11);
      chk("u13_4_q", quotient, 8'd3); chk("u13_4_r", remainder, 8'd1);
      finish_op();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
